// File: rtl/instructions_pkg.sv
// instructions_pkg: shared widths, RV32I load/store funct3 codes and LSU FSM states
package instructions_pkg;

    localparam int XLEN         = 32;
    localparam int MSB_REG_FILE = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

    // size is funct3[1:0]: words need addr[1:0]==0, halves need addr[0]==0
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return size[1] ? (addr_lo != 2'b00) : (size[0] & addr_lo[0]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable/write-data lane steering for stores and extract/extend for loads
module lsu_align
    import instructions_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data,
    output logic            misaligned
);

    logic [15:0] shifted;

    // store lanes replicate the datum so any enabled lane carries it; loads shift the addressed lane down
    always_comb begin
        be         = size[1] ? 4'b1111 : ((size[0] ? 4'b0011 : 4'b0001) << addr_lo);
        wdata      = size[1] ? store_data : size[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
        misaligned = is_misaligned(size, addr_lo);
        shifted    = 16'(rdata >> {ld_addr_lo, 3'b000});
        ld_data    = ld_funct3[1] ? rdata :
                     ld_funct3[0] ? {{16{~ld_funct3[2] & shifted[15]}}, shifted} :
                                    {{24{~ld_funct3[2] & shifted[7]}}, shifted[7:0]};
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-stage unit (ALU passthrough, loads/stores over a req/gnt/rvalid bus)
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a load whose response never arrives.
module mem_access
    import instructions_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         alu_result,
    input  logic [XLEN-1:0]         store_data,
    input  logic [MSB_REG_FILE-1:0] rd_in,
    input  logic [XLEN-1:0]         pc_pls4_in,
    input  logic                    sel_next_pc_in,
    input  logic                    ctrl_reg_wr_in,
    input  logic                    mem_rd,
    input  logic                    mem_wr,
    input  logic [2:0]              funct3,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [XLEN-1:0]         dmem_addr,
    output logic [XLEN-1:0]         dmem_wdata,
    output logic [3:0]              dmem_be,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [XLEN-1:0]         dmem_rdata,
    output logic [XLEN-1:0]         AluData,
    output logic [XLEN-1:0]         pc_pls4,
    output logic [MSB_REG_FILE-1:0] rd,
    output logic                    sel_next_pc,
    output logic                    ctrl_reg_wr,
    output logic                    wb_valid,
    output logic                    misalign_err,
    output logic                    bus_err
);

    state_t state, state_nxt;
    logic accept, misaligned, done, done_wr, use_in, mis, berr, timeout;
    logic [XLEN-1:0] done_data, ld_data, addr_q, wdata_q, pc_q, al_wdata;
    logic [3:0] be_q, al_be;
    logic [2:0] f3_q;
    logic [MSB_REG_FILE-1:0] rd_q;
    logic we_q, sel_q, wr_q;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid & in_ready;
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_be    = dmem_req ? be_q : 4'b0000;
    assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_wdata = wdata_q;

    lsu_align u_align (
        .size       (funct3[1:0]),
        .addr_lo    (alu_result[1:0]),
        .store_data (store_data),
        .ld_funct3  (f3_q),
        .ld_addr_lo (addr_q[1:0]),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .ld_data    (ld_data),
        .misaligned (misaligned)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;

    assign timeout = (state == WAIT_RSP) && (tcnt == TLIM);

    // cycles spent waiting for a load response since the grant
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) tcnt <= '0;
        else if (state == REQ && dmem_gnt) tcnt <= '0;
        else if (state == WAIT_RSP) tcnt <= tcnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state <= IDLE;
        else state <= state_nxt;
    end

    // next state and completion of the current op (done = writeback next cycle)
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        done_data = alu_result;
        done_wr   = ctrl_reg_wr_in;
        use_in    = 1'b1;
        mis       = 1'b0;
        berr      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!(mem_rd | mem_wr)) done = 1'b1;
                    else if (misaligned) begin
                        done    = 1'b1;
                        mis     = 1'b1;
                        done_wr = 1'b0;
                    end else state_nxt = REQ;
                end
            end
            REQ: begin
                use_in    = 1'b0;
                done_data = addr_q;
                done_wr   = 1'b0;
                if (dmem_gnt) begin
                    done      = we_q;
                    state_nxt = we_q ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                use_in    = 1'b0;
                done_data = ld_data;
                done_wr   = wr_q;
                if (dmem_rvalid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    done      = 1'b1;
                    berr      = 1'b1;
                    done_wr   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // capture the memory op so bus outputs stay stable until grant/response
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            pc_q    <= '0;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else if (accept && (mem_rd | mem_wr) && !misaligned) begin
            addr_q  <= alu_result;
            wdata_q <= al_wdata;
            be_q    <= al_be;
            f3_q    <= funct3;
            we_q    <= mem_wr;
            rd_q    <= rd_in;
            pc_q    <= pc_pls4_in;
            sel_q   <= sel_next_pc_in;
            wr_q    <= ctrl_reg_wr_in;
        end
    end

    // writeback register: pulses for one cycle, holds data otherwise
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wb_valid     <= 1'b0;
            ctrl_reg_wr  <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            AluData      <= '0;
            pc_pls4      <= '0;
            rd           <= '0;
            sel_next_pc  <= 1'b0;
        end else begin
            wb_valid     <= done;
            ctrl_reg_wr  <= done & done_wr;
            misalign_err <= mis;
            bus_err      <= berr;
            if (done) begin
                AluData     <= done_data;
                pc_pls4     <= use_in ? pc_pls4_in : pc_q;
                rd          <= use_in ? rd_in : rd_q;
                sel_next_pc <= use_in ? sel_next_pc_in : sel_q;
            end
        end
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, number of cycles allowed between grant and response before abort; used only when MEM_ACCESS_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-high reset (1 = reset asserted).
REQ-004 in_valid  input  1 / in_ready  output  1  execute-stage handshake; an op is accepted when both are 1.
REQ-005 alu_result  input  XLEN  effective address or ALU result / store_data  input  XLEN  rs2 value.
REQ-006 rd_in  input  MSB_REG_FILE / pc_pls4_in  input  XLEN / sel_next_pc_in  input  1 / ctrl_reg_wr_in  input  1  sideband forwarded to writeback.
REQ-007 mem_rd, mem_wr  input  1 each  load/store select (both 0 = non-memory op) / funct3  input  3  RV32I size/sign code.
REQ-008 dmem_req  output  1 / dmem_we  output  1 / dmem_addr  output  XLEN (word aligned) / dmem_wdata  output  XLEN / dmem_be  output  4 / dmem_gnt  input  1 / dmem_rvalid  input  1 / dmem_rdata  input  XLEN.
REQ-009 AluData  output  XLEN / pc_pls4  output  XLEN / rd  output  MSB_REG_FILE / sel_next_pc  output  1 / ctrl_reg_wr  output  1  registered writeback-stage inputs.
REQ-010 wb_valid  output  1  outputs hold a completed op for exactly one cycle / misalign_err  output  1 / bus_err  output  1  one-cycle fault pulses aligned with wb_valid.

Function
REQ-011 FSM states IDLE, REQ, WAIT_RSP; in_ready is 1 only in IDLE.
REQ-012 Non-memory op accepted in IDLE: next cycle wb_valid=1, AluData=alu_result, sideband copied; latency 1; FSM stays IDLE.
REQ-013 Load/store accepted in IDLE, aligned: go to REQ; dmem_req=1 with addr={alu_result[XLEN-1:2],2'b00}, dmem_we=mem_wr; all dmem outputs held stable until dmem_gnt.
REQ-014 REQ with dmem_gnt=1: store -> wb_valid next cycle, ctrl_reg_wr forced 0, back to IDLE; load -> WAIT_RSP.
REQ-015 WAIT_RSP with dmem_rvalid=1: AluData = extracted, extended load data, wb_valid next cycle, back to IDLE; dmem_rvalid outside WAIT_RSP is ignored.
REQ-016 Byte lanes: SB be=0001<<addr[1:0], SH be=0011<<addr[1:0], SW be=1111; wdata replicates byte/half across lanes.
REQ-017 Load extract by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW raw word.
REQ-018 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no dmem_req; next cycle wb_valid=1, misalign_err=1, ctrl_reg_wr=0; stay IDLE.
REQ-019 mem_rd and mem_wr both 1 is treated as a store.
REQ-020 wb_valid=0 cycles keep ctrl_reg_wr=0; other outputs hold last value.

Reset
REQ-021 On rstn=1 asynchronously: FSM=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, wb_valid=0, ctrl_reg_wr=0, sel_next_pc=0, errors=0, data/address/rd outputs=0, timeout counter=0.
REQ-022 Reset during REQ/WAIT_RSP abandons the transaction; a late dmem_rvalid after reset release is ignored (FSM in IDLE).

Configuration
REQ-023 MEM_ACCESS_TIMEOUT_EN defined: counter clears on grant, increments in WAIT_RSP; reaching TIMEOUT_CYCLES without rvalid -> wb_valid=1, bus_err=1, ctrl_reg_wr=0, IDLE.
REQ-024 MEM_ACCESS_TIMEOUT_EN undefined: no counter, WAIT_RSP waits indefinitely, bus_err tied 0.

Structure
REQ-025 XLEN, MSB_REG_FILE, funct3 load/store encodings and the FSM state enum live in instructions_pkg.
REQ-026 Sub-module lsu_align (combinational byte-enable/wdata generation and load extraction) instantiated once.

Verification
REQ-027 ADD result 0x0000_1234, rd=5, ctrl_reg_wr=1 -> next cycle wb_valid=1, AluData=0x1234, rd=5, no dmem_req.
REQ-028 LB addr 0x103, gnt after 2 cycles, rdata 0x80FF_0000 -> AluData=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-029 SH addr 0x102, store_data 0x0000_ABCD -> dmem_addr 0x100, be=1100, wdata=0xABCD_ABCD, ctrl_reg_wr=0.
REQ-030 LW addr 0x101 -> no dmem_req, misalign_err=1, wb_valid=1, ctrl_reg_wr=0.
REQ-031 LW granted, rvalid withheld 16 cycles -> with macro bus_err=1 at cycle 16; without, in_ready stays 0.
REQ-032 rstn pulsed during WAIT_RSP, rvalid arriving afterwards -> all outputs at reset values, no wb_valid.
